// File: rtl/packet_storer_if.sv
// Store-path bundle: request/done handshake toward the requester, write/ack channel toward the memory controller.
// master = packet_storer side, slave = requester + memory controller side.
interface packet_storer_if #(
    parameter int PACKET_WIDTH = 175
);
    logic [31:0]             opaddr;
    logic                    receive_st_valid;
    logic [31:0]             receive_st_addr;
    logic [PACKET_WIDTH-1:0] receive_st_data;
    logic                    receive_st_ready;
    logic                    mem_send_addr_valid;
    logic [31:0]             mem_send_addr;
    logic                    mem_send_data_valid;
    logic [31:0]             mem_send_data;
    logic                    mem_send_ready;
    logic                    mem_receive_valid;
    logic [31:0]             mem_receive_data;
    logic                    mem_receive_ready;
    logic                    send_done_valid;
    logic [31:0]             send_done_addr;
    logic                    send_done_ready;

    modport master (
        input  opaddr,
        input  receive_st_valid, receive_st_addr, receive_st_data,
        output receive_st_ready,
        output mem_send_addr_valid, mem_send_addr, mem_send_data_valid, mem_send_data,
        input  mem_send_ready,
        input  mem_receive_valid, mem_receive_data,
        output mem_receive_ready,
        output send_done_valid, send_done_addr,
        input  send_done_ready
    );

    modport slave (
        output opaddr,
        output receive_st_valid, receive_st_addr, receive_st_data,
        input  receive_st_ready,
        input  mem_send_addr_valid, mem_send_addr, mem_send_data_valid, mem_send_data,
        output mem_send_ready,
        output mem_receive_valid, mem_receive_data,
        input  mem_receive_ready,
        input  send_done_valid, send_done_addr,
        output send_done_ready
    );
endinterface

// File: rtl/packet_storer.sv
// Serialises a captured 175-bit packet into six 32-bit writes (MSB word first), one write outstanding at a time.
// Accept-to-done-valid is 19 cycles unstalled; every handshake holds its outputs indefinitely while the peer stalls.
module packet_storer (
    input  logic            clk_i,
    input  logic            rst_i,
    packet_storer_if.master bus
);
    localparam int         PACKET_WIDTH = 175;
    localparam logic [2:0] LAST_WORD    = 3'd5;

    typedef enum logic [1:0] {
        S_RECEIVE,
        S_MEM_SEND,
        S_MEM_ACK,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [2:0]              k_q;
    logic [31:0]             addr_q;
    logic [PACKET_WIDTH-1:0] data_q;
    logic                    st_rdy_q;
    logic                    mem_vld_q;
    logic                    done_vld_q;
    logic [31:0]             wr_word_d;
    logic                    unused_rdata;

    // Word layout matches the loader: five full words from the top, then the 15-bit tail zero-extended.
    always_comb begin
        wr_word_d = '0;
        case (k_q)
            3'd0:    wr_word_d = data_q[PACKET_WIDTH-1   -: 32];
            3'd1:    wr_word_d = data_q[PACKET_WIDTH-33  -: 32];
            3'd2:    wr_word_d = data_q[PACKET_WIDTH-65  -: 32];
            3'd3:    wr_word_d = data_q[PACKET_WIDTH-97  -: 32];
            3'd4:    wr_word_d = data_q[PACKET_WIDTH-129 -: 32];
            3'd5:    wr_word_d = {17'd0, data_q[14:0]};
            default: wr_word_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_RECEIVE;
            k_q        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            st_rdy_q   <= 1'b0;
            mem_vld_q  <= 1'b0;
            done_vld_q <= 1'b0;
        end else begin
            case (state_q)
                S_RECEIVE: begin
                    if (st_rdy_q && bus.receive_st_valid) begin
                        addr_q   <= bus.receive_st_addr;
                        data_q   <= bus.receive_st_data;
                        k_q      <= '0;
                        st_rdy_q <= 1'b0;
                        state_q  <= S_MEM_SEND;
                    end else if (!st_rdy_q) begin
                        st_rdy_q <= 1'b1;
                    end
                end
                S_MEM_SEND: begin
                    if (mem_vld_q && bus.mem_send_ready) begin
                        mem_vld_q <= 1'b0;
                        state_q   <= S_MEM_ACK;
                    end else if (!mem_vld_q) begin
                        mem_vld_q <= 1'b1;
                    end
                end
                S_MEM_ACK: begin
                    // Acks are only meaningful here; anywhere else they are stale or spurious.
                    if (bus.mem_receive_valid) begin
                        if (k_q == LAST_WORD) begin
                            k_q     <= '0;
                            state_q <= S_DONE;
                        end else begin
                            k_q     <= k_q + 3'd1;
                            state_q <= S_MEM_SEND;
                        end
                    end
                end
                S_DONE: begin
                    if (done_vld_q && bus.send_done_ready) begin
                        done_vld_q <= 1'b0;
                        state_q    <= S_RECEIVE;
                    end else if (!done_vld_q) begin
                        done_vld_q <= 1'b1;
                    end
                end
                default: state_q <= S_RECEIVE;
            endcase
        end
    end

    assign bus.receive_st_ready    = st_rdy_q;
    assign bus.mem_send_addr_valid = mem_vld_q;
    assign bus.mem_send_data_valid = mem_vld_q;
    assign bus.mem_send_addr       = bus.opaddr + addr_q + {27'd0, k_q, 2'b00};
    assign bus.mem_send_data       = wr_word_d;
    assign bus.mem_receive_ready   = 1'b1;
    assign bus.send_done_valid     = done_vld_q;
    assign bus.send_done_addr      = addr_q;

    assign unused_rdata = ^bus.mem_receive_data;
endmodule

// File: tb/tb_packet_storer.sv
// Directed, table-driven bench for packet_storer: each record is one store with its expected write trace.
// Records also carry the corner-case knobs (write stall, done stall, spurious acks, reset abort, chained request).
module tb_packet_storer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    packet_storer_if bus ();

    packet_storer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  opaddr;
        logic [31:0]  addr;
        logic [174:0] pkt;
        logic [31:0]  ea [6];
        logic [31:0]  ed [6];
        int           bp_w;
        int           bp_n;
        int           dn_bp;
        int           abort_w;
        bit           spur;
        bit           chain;
    } vec_t;

    vec_t v [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no event, want event within budget", nm);
    endtask

    function automatic vec_t mk(input logic [31:0] op, input logic [31:0] a, input logic [174:0] p);
        vec_t r;
        r.opaddr  = op;
        r.addr    = a;
        r.pkt     = p;
        r.bp_w    = -1;
        r.bp_n    = 0;
        r.dn_bp   = 0;
        r.abort_w = -1;
        r.spur    = 1'b0;
        r.chain   = 1'b0;
        r.ea      = '{default: '0};
        r.ed      = '{default: '0};
        return r;
    endfunction

    task automatic run(input int i);
        int c;
        int n;
        int extra;
        bus.opaddr          = v[i].opaddr;
        bus.send_done_ready = (v[i].dn_bp == 0);
        bus.mem_send_ready  = 1'b1;
        if (v[i].spur) begin
            bus.mem_receive_valid = 1'b1;
            @(negedge clk);
            bus.mem_receive_valid = 1'b0;
        end
        bus.receive_st_valid = 1'b1;
        bus.receive_st_addr  = v[i].addr;
        bus.receive_st_data  = v[i].pkt;
        n = 0;
        while (!bus.receive_st_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.receive_st_ready) begin
            timeout($sformatf("v%0d st_ready", i));
            bus.receive_st_valid = 1'b0;
            return;
        end
        @(negedge clk);
        c = 0;
        bus.receive_st_valid = 1'b0;
        chk1($sformatf("v%0d st_ready_fall", i), bus.receive_st_ready, 1'b0);
        extra = 0;
        for (int w = 0; w < 6; w++) begin
            n = 0;
            while (!bus.mem_send_addr_valid && n < 50) begin @(negedge clk); c++; n++; end
            if (!bus.mem_send_addr_valid) begin
                timeout($sformatf("v%0d w%0d valid", i, w));
                return;
            end
            chk($sformatf("v%0d w%0d valid_cycle", i, w), c, 1 + 3 * w + extra);
            chk($sformatf("v%0d w%0d addr", i, w), bus.mem_send_addr, v[i].ea[w]);
            chk($sformatf("v%0d w%0d data", i, w), bus.mem_send_data, v[i].ed[w]);
            chk1($sformatf("v%0d w%0d data_valid", i, w), bus.mem_send_data_valid, 1'b1);
            if (w == v[i].abort_w) begin
                bus.mem_send_ready = 1'b0;
                @(negedge clk);
                chk1($sformatf("v%0d abort pre valid", i), bus.mem_send_addr_valid, 1'b1);
                #2 rst = 1'b1;
                #1;
                chk1($sformatf("v%0d abort addr_valid", i), bus.mem_send_addr_valid, 1'b0);
                chk1($sformatf("v%0d abort data_valid", i), bus.mem_send_data_valid, 1'b0);
                chk1($sformatf("v%0d abort st_ready", i), bus.receive_st_ready, 1'b0);
                chk1($sformatf("v%0d abort done_valid", i), bus.send_done_valid, 1'b0);
                chk1($sformatf("v%0d abort rcv_ready", i), bus.mem_receive_ready, 1'b1);
                bus.mem_receive_valid = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                bus.mem_receive_valid = 1'b0;
                bus.mem_send_ready    = 1'b1;
                chk1($sformatf("v%0d post-reset st_ready", i), bus.receive_st_ready, 1'b1);
                chk1($sformatf("v%0d post-reset valid", i), bus.mem_send_addr_valid, 1'b0);
                return;
            end
            if (w == v[i].bp_w) begin
                bus.mem_send_ready = 1'b0;
                repeat (v[i].bp_n) begin
                    @(negedge clk); c++;
                    chk1($sformatf("v%0d hold addr_valid c%0d", i, c), bus.mem_send_addr_valid, 1'b1);
                    chk1($sformatf("v%0d hold data_valid c%0d", i, c), bus.mem_send_data_valid, 1'b1);
                    chk($sformatf("v%0d hold addr c%0d", i, c), bus.mem_send_addr, v[i].ea[w]);
                    chk($sformatf("v%0d hold data c%0d", i, c), bus.mem_send_data, v[i].ed[w]);
                end
                bus.mem_send_ready = 1'b1;
                extra = v[i].bp_n;
            end
            // With spur set, the ack also arrives in the acceptance cycle, where it must be ignored.
            if (v[i].spur) bus.mem_receive_valid = 1'b1;
            @(negedge clk); c++;
            chk1($sformatf("v%0d w%0d accepted", i, w), bus.mem_send_addr_valid, 1'b0);
            bus.mem_receive_valid = 1'b1;
            @(negedge clk); c++;
            bus.mem_receive_valid = 1'b0;
        end
        n = 0;
        while (!bus.send_done_valid && n < 50) begin @(negedge clk); c++; n++; end
        if (!bus.send_done_valid) begin
            timeout($sformatf("v%0d done", i));
            return;
        end
        chk($sformatf("v%0d done_cycle", i), c, 19 + extra);
        chk($sformatf("v%0d done_addr", i), bus.send_done_addr, v[i].addr);
        if (v[i].chain) begin
            bus.opaddr           = v[i+1].opaddr;
            bus.receive_st_valid = 1'b1;
            bus.receive_st_addr  = v[i+1].addr;
            bus.receive_st_data  = v[i+1].pkt;
        end
        if (v[i].spur) bus.mem_receive_valid = 1'b1;
        repeat (v[i].dn_bp) begin
            @(negedge clk); c++;
            bus.mem_receive_valid = 1'b0;
            chk1($sformatf("v%0d done hold c%0d", i, c), bus.send_done_valid, 1'b1);
            chk1($sformatf("v%0d st_ready low c%0d", i, c), bus.receive_st_ready, 1'b0);
        end
        bus.send_done_ready = 1'b1;
        @(negedge clk); c++;
        bus.mem_receive_valid = 1'b0;
        chk1($sformatf("v%0d done fall", i), bus.send_done_valid, 1'b0);
        chk1($sformatf("v%0d st_ready still low", i), bus.receive_st_ready, 1'b0);
        @(negedge clk); c++;
        chk1($sformatf("v%0d st_ready rise", i), bus.receive_st_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100us");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        v[0] = mk(32'h0000_1000, 32'h40,
                  {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 15'h7ABC});
        v[0].ea = '{32'h1040, 32'h1044, 32'h1048, 32'h104C, 32'h1050, 32'h1054};
        v[0].ed = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h00007ABC};

        v[1] = mk(32'h0000_1000, 32'h40,
                  {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 15'h7FFF});
        v[1].ea = '{32'h1040, 32'h1044, 32'h1048, 32'h104C, 32'h1050, 32'h1054};
        v[1].ed = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h00007FFF};
        v[1].bp_w = 2;
        v[1].bp_n = 5;

        v[2] = mk(32'hFFFF_FFF0, 32'h8,
                  {32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 15'h0001});
        v[2].ea = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        v[2].ed = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000001};

        v[3] = mk(32'h0000_2000, 32'h20,
                  {32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008, 32'h80000000, 15'h4000});
        v[3].ea = '{32'h2020, 32'h2024, 32'h2028, 32'h202C, 32'h2030, 32'h2034};
        v[3].ed = '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008, 32'h80000000, 32'h00004000};
        v[3].spur = 1'b1;

        v[4] = mk(32'h0000_3000, 32'h0,
                  {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 15'h1234});
        v[4].ea = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014};
        v[4].ed = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'h00001234};
        v[4].abort_w = 3;

        v[5] = mk(32'h0000_4000, 32'h100,
                  {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000, 32'h0BADF00D, 15'h3C3C});
        v[5].ea = '{32'h4100, 32'h4104, 32'h4108, 32'h410C, 32'h4110, 32'h4114};
        v[5].ed = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F000, 32'h0BADF00D, 32'h00003C3C};
        v[5].dn_bp = 3;
        v[5].chain = 1'b1;

        v[6] = mk(32'h0000_5000, 32'h8,
                  {32'hFEDCBA98, 32'h76543210, 32'h00FF00FF, 32'hFF00FF00, 32'hC3C3C3C3, 15'h5555});
        v[6].ea = '{32'h5008, 32'h500C, 32'h5010, 32'h5014, 32'h5018, 32'h501C};
        v[6].ed = '{32'hFEDCBA98, 32'h76543210, 32'h00FF00FF, 32'hFF00FF00, 32'hC3C3C3C3, 32'h00005555};

        rst                   = 1'b1;
        bus.opaddr            = '0;
        bus.receive_st_valid  = 1'b0;
        bus.receive_st_addr   = '0;
        bus.receive_st_data   = '0;
        bus.mem_send_ready    = 1'b1;
        bus.mem_receive_valid = 1'b0;
        bus.mem_receive_data  = 32'hBAD0BAD0;
        bus.send_done_ready   = 1'b1;

        #3;
        chk1("reset st_ready", bus.receive_st_ready, 1'b0);
        chk1("reset addr_valid", bus.mem_send_addr_valid, 1'b0);
        chk1("reset data_valid", bus.mem_send_data_valid, 1'b0);
        chk1("reset done_valid", bus.send_done_valid, 1'b0);
        chk1("reset rcv_ready", bus.mem_receive_ready, 1'b1);
        chk("reset done_addr", bus.send_done_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk1("reset st_ready before edge", bus.receive_st_ready, 1'b0);
        @(negedge clk);
        chk1("st_ready first edge", bus.receive_st_ready, 1'b1);

        for (int i = 0; i < 7; i++) run(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/packet_storer.md
# packet_storer

Write-side counterpart of the packet loader: accepts a store request (byte offset + full packet), serialises the packet into six 32-bit memory writes through the memory controller, waits for the controller's per-write acknowledge, then reports completion to the requester. It sits between the memory accessor (store path) and the memory controller. Word layout and address arithmetic are exactly those the loader uses to read packets back.

## Interface
- PACKET_WIDTH, 175, packet width in bits; fixed at 5*32+15, no other value supported
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- OPADDR  in  32  packet-region base byte address; sampled combinationally every write
- RECEIVE_ST_VALID  in  1  store request valid
- RECEIVE_ST_ADDR  in  32  byte offset of packet within region
- RECEIVE_ST_DATA  in  PACKET_WIDTH  packet to store
- RECEIVE_ST_READY  out  1  storer can accept a request (registered)
- MEM_SEND_ADDR_VALID  out  1  write address valid (registered)
- MEM_SEND_ADDR  out  32  write byte address
- MEM_SEND_DATA_VALID  out  1  write data valid; always equal to MEM_SEND_ADDR_VALID
- MEM_SEND_DATA  out  32  write data word
- MEM_SEND_READY  in  1  controller accepts address+data
- MEM_RECEIVE_VALID  in  1  controller write acknowledge
- MEM_RECEIVE_DATA  in  32  ignored
- MEM_RECEIVE_READY  out  1  constant 1
- SEND_DONE_VALID  out  1  store complete (registered)
- SEND_DONE_ADDR  out  32  captured RECEIVE_ST_ADDR of completed store
- SEND_DONE_READY  in  1  requester accepts completion

## Operation
- States: S_RECEIVE, S_MEM_SEND, S_MEM_ACK, S_DONE. Reset state S_RECEIVE.
- S_RECEIVE: on RECEIVE_ST_VALID && RECEIVE_ST_READY capture addr and data, word counter k=0, go S_MEM_SEND.
- S_MEM_SEND: present word k; on MEM_SEND_ADDR_VALID && MEM_SEND_READY go S_MEM_ACK.
- S_MEM_ACK: on MEM_RECEIVE_VALID: if k==5, k<=0, go S_DONE; else k<=k+1, go S_MEM_SEND. MEM_RECEIVE_VALID in any other state is ignored (no counter/state change).
- S_DONE: on SEND_DONE_VALID && SEND_DONE_READY go S_RECEIVE.
- MEM_SEND_ADDR = OPADDR + captured_addr + 4*k, 32-bit, wraps modulo 2^32, no overflow flag.
- Word k (0..4) = packet[PACKET_WIDTH-1-32k -: 32] (MSB first). Word 5 = {17'b0, packet[14:0]}.
- MEM_SEND_DATA and MEM_SEND_ADDR stable while MEM_SEND_ADDR_VALID high and not accepted.
- Registered handshake outputs: READY/VALID rises on the first edge the owning state is active and the signal is low; falls on the edge it completes a handshake. RECEIVE_ST_READY owned by S_RECEIVE, MEM_SEND_*_VALID by S_MEM_SEND, SEND_DONE_VALID by S_DONE.
- Captured data/addr held unchanged from capture until next capture.

## Timing
- Reset (async, any state, mid-transfer included): STATE=S_RECEIVE, k=0, captured addr/data=0, RECEIVE_ST_READY=0, MEM_SEND_ADDR_VALID=MEM_SEND_DATA_VALID=0, SEND_DONE_VALID=0, MEM_RECEIVE_READY=1; in-flight write abandoned, late acks ignored. RECEIVE_ST_READY rises on first edge after RST deasserts.
- With MEM_SEND_READY=1 and ack one cycle after acceptance: request accept edge E0; word k valid rises E0+1+3k, accepted E0+2+3k, acked E0+3+3k; SEND_DONE_VALID rises E0+19; with SEND_DONE_READY=1 handshake E0+20, RECEIVE_ST_READY rises E0+21.
- MEM_SEND_READY low: valid, addr, data held indefinitely; no timeout.
- Ack asserted in the same cycle as write acceptance: ignored (state still S_MEM_SEND); controller must ack after acceptance.
- Exactly one outstanding write; never more than one request in flight.

## Test plan
- Basic store: OPADDR=0x1000, addr=0x40, packet words 0x11111111..0x55555555, low 15 bits 0x7ABC -> six writes at 0x1040,0x1044,...,0x1054 with data 0x11111111..0x55555555, 0x00007ABC; SEND_DONE_ADDR=0x40; done valid at E0+19.
- Backpressure: MEM_SEND_READY low 5 cycles on word 2 -> addr 0x1048 and data held stable, both valids high, single write issued; done delayed by 5 cycles.
- Address wrap: OPADDR=0xFFFFFFF0, addr=0x8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8, 0xC.
- Spurious ack: MEM_RECEIVE_VALID pulsed in S_RECEIVE, S_MEM_SEND, S_DONE -> no counter or state change, write sequence unchanged.
- Reset mid-operation: assert RST while word 3 valid and MEM_SEND_READY low -> all valids 0 immediately (same cycle, async); new request afterwards starts at word 0 with new addresses.
- Done backpressure + back-to-back: SEND_DONE_READY low 3 cycles, second request pending -> RECEIVE_ST_READY stays 0 until done handshake, second request accepted exactly 1 cycle after READY rises.
